instr_realigner: RTL and testbench

- Sits between instruction fetch and the RVC decompressor/decoder.
- Accepts word-aligned 32-bit fetch words and splits them into a stream of 16-bit compressed and 32-bit uncompressed instructions, each tagged with its own PC.
- Joins 32-bit instructions that straddle a word boundary.
- Supports flush/redirect to halfword-aligned targets and discards stale in-flight fetch words.

---
 rtl/instr_realigner.sv | 101 ++++++++++
 tb/tb_instr_realigner.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_realigner.sv
// Instruction realigner: splits word-aligned fetch words into 16/32-bit
// instructions with their own PCs, joining 32-bit instructions that straddle words.
module instr_realigner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [31:0] fetch_addr,
  input  logic [31:0] fetch_data,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic        instr_is_compressed,
  output logic [31:0] instr_pc
);

  logic [15:0] q [3];
  logic [15:0] q_nxt [3];
  logic [1:0]  cnt, cnt_nxt, rem, pop_cnt;
  logic [31:0] head_pc, exp_addr;
  logic        drop_first;
  logic        comp, consume, accept, push_ok;
  logic [15:0] first_hw;

  assign comp                = q[0][1:0] != 2'b11;
  assign instr_valid         = !flush && (cnt >= 2'd2 || (cnt == 2'd1 && comp));
  assign instr_data          = comp ? {16'h0000, q[0]} : {q[1], q[0]};
  assign instr_is_compressed = comp && (cnt != 2'd0);
  assign instr_pc            = head_pc;
  assign fetch_ready         = !flush && (cnt <= 2'd1);

  assign consume  = instr_valid && instr_ready;
  assign accept   = fetch_valid && fetch_ready;
  // Words whose address does not match are stale from before a redirect.
  assign push_ok  = accept && (fetch_addr == exp_addr);
  assign pop_cnt  = consume ? (comp ? 2'd1 : 2'd2) : 2'd0;
  assign rem      = cnt - pop_cnt;
  assign first_hw = drop_first ? fetch_data[31:16] : fetch_data[15:0];

  always_comb begin
    q_nxt   = q;
    cnt_nxt = rem;
    case (pop_cnt)
      2'd1: begin
        q_nxt[0] = q[1];
        q_nxt[1] = q[2];
        q_nxt[2] = 16'h0000;
      end
      2'd2: begin
        q_nxt[0] = q[2];
        q_nxt[1] = 16'h0000;
        q_nxt[2] = 16'h0000;
      end
      default: ;
    endcase
    // Push lands behind whatever survives the pop; accept implies rem <= 1.
    if (push_ok) begin
      cnt_nxt = rem + (drop_first ? 2'd1 : 2'd2);
      case (rem)
        2'd0: begin
          q_nxt[0] = first_hw;
          if (!drop_first) q_nxt[1] = fetch_data[31:16];
        end
        2'd1: begin
          q_nxt[1] = first_hw;
          if (!drop_first) q_nxt[2] = fetch_data[31:16];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q          <= '{default: 16'h0000};
      cnt        <= 2'd0;
      head_pc    <= RESET_PC & ~32'd1;
      exp_addr   <= RESET_PC & ~32'd3;
      drop_first <= RESET_PC[1];
    end else if (flush) begin
      q          <= '{default: 16'h0000};
      cnt        <= 2'd0;
      head_pc    <= flush_pc & ~32'd1;
      exp_addr   <= flush_pc & ~32'd3;
      drop_first <= flush_pc[1];
    end else begin
      q   <= q_nxt;
      cnt <= cnt_nxt;
      if (consume) head_pc <= head_pc + (comp ? 32'd2 : 32'd4);
      if (push_ok) begin
        exp_addr   <= exp_addr + 32'd4;
        drop_first <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_realigner.sv
// Directed bench for instr_realigner: hand-listed expected instruction stream
// checked by a negedge monitor, plus cycle-level checks of stalls, flush and reset.
module tb_instr_realigner;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_valid = 1'b0;
  logic        fetch_ready;
  logic [31:0] fetch_addr = 32'h0;
  logic [31:0] fetch_data = 32'h0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instr_data;
  logic        instr_is_compressed;
  logic [31:0] instr_pc;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] d;
    logic [31:0] pc;
    logic        c;
  } exp_t;
  exp_t exp_q[$];

  instr_realigner #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_addr(fetch_addr), .fetch_data(fetch_data),
    .flush(flush), .flush_pc(flush_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_is_compressed(instr_is_compressed),
    .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_instr(input logic [31:0] d, input logic [31:0] pc, input logic c);
    exp_t e;
    e.d = d; e.pc = pc; e.c = c;
    exp_q.push_back(e);
  endtask

  task automatic feed(input logic [31:0] addr, input logic [31:0] data);
    logic acc;
    int   n;
    fetch_valid = 1'b1;
    fetch_addr  = addr;
    fetch_data  = data;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      acc = fetch_ready;
      cyc();
      n++;
    end
    fetch_valid = 1'b0;
    if (!acc) check_val("feed_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc();
    check_val(tag, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    fetch_valid = 1'b0;
    flush = 1'b0;
    instr_ready = 1'b1;
    exp_q.delete();
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        check_val("extra_instr", instr_data, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check_val("mon_data", instr_data, e.d);
        check_val("mon_pc", instr_pc, e.pc);
        check_val("mon_comp", {31'd0, instr_is_compressed}, {31'd0, e.c});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    cyc();
    check_val("rst_ready", {31'd0, fetch_ready}, 32'd1);
    check_val("rst_valid", {31'd0, instr_valid}, 32'd0);
    check_val("rst_data", instr_data, 32'h0);
    check_val("rst_comp", {31'd0, instr_is_compressed}, 32'd0);
    check_val("rst_pc", instr_pc, 32'h0);
    do_reset();

    // 1: aligned words
    expect_instr(32'h00A0_0093, 32'h0, 1'b0);
    expect_instr(32'h0000_4501, 32'h4, 1'b1);
    expect_instr(32'h0000_4505, 32'h6, 1'b1);
    feed(32'h0, 32'h00A0_0093);
    check_val("t1_valid", {31'd0, instr_valid}, 32'd1);
    check_val("t1_data", instr_data, 32'h00A0_0093);
    check_val("t1_full", {31'd0, fetch_ready}, 32'd0);
    feed(32'h4, 32'h4505_4501);
    drain("t1_drain");
    check_val("t1_idle", {31'd0, instr_valid}, 32'd0);

    // 2: straddling 32-bit instruction
    do_reset();
    expect_instr(32'h0000_4501, 32'h0, 1'b1);
    expect_instr(32'h00A0_0093, 32'h2, 1'b0);
    expect_instr(32'h0000_4505, 32'h6, 1'b1);
    feed(32'h0, 32'h0093_4501);
    cyc();
    check_val("t2_gap_valid", {31'd0, instr_valid}, 32'd0);
    check_val("t2_gap_ready", {31'd0, fetch_ready}, 32'd1);
    check_val("t2_gap_comp", {31'd0, instr_is_compressed}, 32'd0);
    cyc();
    check_val("t2_gap_valid2", {31'd0, instr_valid}, 32'd0);
    feed(32'h4, 32'h4505_00A0);
    drain("t2_drain");

    // 3: backpressure with the queue full
    do_reset();
    expect_instr(32'h0000_4501, 32'h0, 1'b1);
    expect_instr(32'h00A0_0093, 32'h2, 1'b0);
    expect_instr(32'h0000_4505, 32'h6, 1'b1);
    feed(32'h0, 32'h0093_4501);
    cyc();
    instr_ready = 1'b0;
    feed(32'h4, 32'h4505_00A0);
    for (int i = 0; i < 5; i++) begin
      check_val("t3_ready", {31'd0, fetch_ready}, 32'd0);
      check_val("t3_valid", {31'd0, instr_valid}, 32'd1);
      check_val("t3_data", instr_data, 32'h00A0_0093);
      check_val("t3_pc", instr_pc, 32'h2);
      cyc();
    end
    instr_ready = 1'b1;
    drain("t3_drain");

    // 4: flush to halfword target, stale words dropped
    flush = 1'b1;
    flush_pc = 32'h0000_0102;
    cyc();
    flush = 1'b0;
    #1;
    check_val("t4_pc", instr_pc, 32'h102);
    check_val("t4_ready", {31'd0, fetch_ready}, 32'd1);
    feed(32'h8, 32'h1111_1111);
    check_val("t4_stale8", {31'd0, instr_valid}, 32'd0);
    feed(32'hC, 32'h2222_2222);
    check_val("t4_stalec", {31'd0, instr_valid}, 32'd0);
    expect_instr(32'h0000_4505, 32'h102, 1'b1);
    feed(32'h100, 32'h4505_4501);
    check_val("t4_data", instr_data, 32'h0000_4505);
    drain("t4_drain");
    check_val("t4_next_pc", instr_pc, 32'h104);
    check_val("t4_idle", {31'd0, instr_valid}, 32'd0);

    // 5: flush collides with consume and accept
    do_reset();
    feed(32'h0, 32'h00A0_0093);
    flush = 1'b1;
    flush_pc = 32'h0000_0041;
    fetch_valid = 1'b1;
    fetch_addr = 32'h4;
    fetch_data = 32'h3333_3333;
    #1;
    check_val("t5_valid_fl", {31'd0, instr_valid}, 32'd0);
    check_val("t5_ready_fl", {31'd0, fetch_ready}, 32'd0);
    cyc();
    check_val("t5_pc", instr_pc, 32'h40);
    flush = 1'b0;
    fetch_valid = 1'b0;
    #1;
    check_val("t5_valid", {31'd0, instr_valid}, 32'd0);
    check_val("t5_ready", {31'd0, fetch_ready}, 32'd1);
    feed(32'h4, 32'h3333_3333);
    check_val("t5_stale", {31'd0, instr_valid}, 32'd0);
    expect_instr(32'h0000_4501, 32'h40, 1'b1);
    expect_instr(32'h0000_4505, 32'h42, 1'b1);
    feed(32'h40, 32'h4505_4501);
    drain("t5_drain");

    // 6: async reset mid-stream
    do_reset();
    instr_ready = 1'b0;
    feed(32'h0, 32'h00A0_0093);
    check_val("t6_pre_valid", {31'd0, instr_valid}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_val("t6_valid", {31'd0, instr_valid}, 32'd0);
    check_val("t6_data", instr_data, 32'h0);
    check_val("t6_pc", instr_pc, 32'h0);
    check_val("t6_ready", {31'd0, fetch_ready}, 32'd1);
    cyc();
    reset = 1'b0;
    instr_ready = 1'b1;
    expect_instr(32'h0000_4501, 32'h0, 1'b1);
    expect_instr(32'h0000_4505, 32'h2, 1'b1);
    feed(32'h0, 32'h4505_4501);
    drain("t6_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
